// File: rtl/jtag_shift_ctrl_if.sv
// Command/response interface of the JTAG scan master.
//
// Purpose : carries scan commands from an agent to jtag_shift_ctrl and the
//           captured TDO data back.
// Signals : cmd_valid_i / cmd_ready_o    command handshake
//           cmd_ir_i, cmd_len_i, cmd_data_i  scan type, length, TDI bits
//           reset_req_i                  request TAP reset sequence
//           rsp_valid_o / rsp_ready_i    response handshake
//           rsp_data_o, rsp_err_o        captured TDO bits, illegal-length flag
// Modports: master = command agent, slave = jtag_shift_ctrl.
interface jtag_shift_ctrl_if #(
    parameter int MAX_LEN = 32
);
    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic               cmd_ir_i;
    logic [5:0]         cmd_len_i;
    logic [MAX_LEN-1:0] cmd_data_i;
    logic               reset_req_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [MAX_LEN-1:0] rsp_data_o;
    logic               rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_ir_i, cmd_len_i, cmd_data_i, reset_req_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_ir_i, cmd_len_i, cmd_data_i, reset_req_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/jtag_shift_ctrl.sv
// Standalone JTAG master: divides `clock` into TCK, walks the debug TAP
// through IR/DR scans issued on the command interface and returns the
// captured TDO bits.
//
// Ports:
//   clock, reset_ni   system clock, asynchronous active-low reset
//   bus               command/response interface (slave side)
//   busy_o            TCK sequence in progress
//   jtag_tck_o/tms_o/tdi_o, jtag_tdo_i, jtag_trst_no   TAP pins
//
// States:
//   state   | meaning
//   S_TLR   | 5x TMS=1 then 1x TMS=0: TAP to Run-Test/Idle
//   S_IDLE  | waiting for command or reset request
//   S_PRE   | walk RTI -> Shift-DR (1,0,0) or Shift-IR (1,1,0,0)
//   S_SHIFT | len periods shifting TDI out / TDO in, TMS=1 on last bit
//   S_POST  | Exit1 -> Update (1) -> Run-Test/Idle (0)
//   S_RSP   | response held until consumed
module jtag_shift_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic             clock,
    input  logic             reset_ni,
    jtag_shift_ctrl_if.slave bus,
    output logic             busy_o,
    output logic             jtag_tck_o,
    output logic             jtag_tms_o,
    output logic             jtag_tdi_o,
    input  logic             jtag_tdo_i,
    output logic             jtag_trst_no
);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [6:0]    LEN_MAX = 7'(MAX_LEN);

    typedef enum logic [2:0] {
        S_TLR,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_RSP
    } state_t;

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               ir_q, ir_d;
    logic [5:0]         len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               trst_q, trst_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    state_t             nstate;
    logic [5:0]         ncnt;
    logic               go;
    logic [PW-1:0]      phase_inc;
    logic [5:0]         seg_len;
    logic               len_ok;

    // TMS value for period c of segment st.
    function automatic logic step_tms(state_t st, logic [5:0] c, logic ir, logic [5:0] len);
        logic m;
        case (st)
            S_TLR:   m = (c < 6'd5);
            S_PRE:   m = (c == 6'd0) || (ir && (c == 6'd1));
            S_SHIFT: m = (c == len - 6'd1);
            S_POST:  m = (c == 6'd0);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic step_tdi(state_t st, logic [5:0] c, logic [MAX_LEN-1:0] d);
        return (st == S_SHIFT) ? d[c[IW-1:0]] : 1'b0;
    endfunction

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_TLR;
            run_q       <= 1'b0;
            phase_q     <= '0;
            cnt_q       <= '0;
            ir_q        <= 1'b0;
            len_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            ir_q        <= ir_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_q      <= trst_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        ir_d        = ir_q;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trst_d      = trst_q;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        nstate      = state_q;
        ncnt        = cnt_q;
        go          = 1'b0;
        phase_inc   = phase_q + PW'(1);
        len_ok      = (bus.cmd_len_i != 6'd0) && ({1'b0, bus.cmd_len_i} <= LEN_MAX);

        case (state_q)
            S_TLR:   seg_len = 6'd6;
            S_PRE:   seg_len = ir_q ? 6'd4 : 6'd3;
            S_SHIFT: seg_len = len_q;
            S_POST:  seg_len = 6'd2;
            default: seg_len = 6'd1;
        endcase

        if (run_q) begin
            if (phase_q == PH_LAST) begin
                // End of a TCK period: step within the segment, chain to the
                // next segment, or stop the clock.
                tck_d   = 1'b0;
                phase_d = '0;
                if (cnt_q + 6'd1 < seg_len) begin
                    ncnt = cnt_q + 6'd1;
                    go   = 1'b1;
                end else begin
                    ncnt = '0;
                    case (state_q)
                        S_TLR:   nstate = S_IDLE;
                        S_PRE: begin
                            nstate = S_SHIFT;
                            go     = 1'b1;
                        end
                        S_SHIFT: begin
                            nstate = S_POST;
                            go     = 1'b1;
                        end
                        S_POST: begin
                            nstate      = S_RSP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = cap_q;
                            rsp_err_d   = 1'b0;
                        end
                        default: nstate = S_IDLE;
                    endcase
                end
                state_d = nstate;
                cnt_d   = ncnt;
                if (go) begin
                    tms_d = step_tms(nstate, ncnt, ir_q, len_q);
                    tdi_d = step_tdi(nstate, ncnt, data_q);
                end else begin
                    run_d  = 1'b0;
                    busy_d = 1'b0;
                    tdi_d  = 1'b0;
                end
            end else begin
                phase_d = phase_inc;
                tck_d   = (phase_inc >= PH_HI);
                // TDO is taken on the edge where TCK goes high.
                if ((phase_inc == PH_HI) && (state_q == S_SHIFT)) begin
                    cap_d[cnt_q[IW-1:0]] = jtag_tdo_i;
                end
            end
        end else begin
            case (state_q)
                S_TLR: begin
                    // First edge after reset only releases TRST; the
                    // sequence starts on the next one.
                    if (!trst_q) begin
                        trst_d = 1'b1;
                    end else begin
                        run_d   = 1'b1;
                        busy_d  = 1'b1;
                        phase_d = '0;
                        cnt_d   = '0;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end
                end
                S_IDLE: begin
                    if (bus.reset_req_i) begin
                        state_d = S_TLR;
                    end else if (bus.cmd_valid_i && !rsp_valid_q) begin
                        ir_d   = bus.cmd_ir_i;
                        len_d  = bus.cmd_len_i;
                        data_d = bus.cmd_data_i;
                        if (!len_ok) begin
                            state_d     = S_RSP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
                            rsp_err_d   = 1'b1;
                        end else begin
                            state_d = S_PRE;
                            run_d   = 1'b1;
                            busy_d  = 1'b1;
                            phase_d = '0;
                            cnt_d   = '0;
                            cap_d   = '0;
                            tms_d   = 1'b1;
                            tdi_d   = 1'b0;
                        end
                    end
                end
                S_RSP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Ready must drop in the same cycle as reset_req_i so that a request
    // and a command arriving together never complete a handshake.
    assign bus.cmd_ready_o = (state_q == S_IDLE) && !rsp_valid_q && !bus.reset_req_i;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign busy_o          = busy_q;
    assign jtag_tck_o      = tck_q;
    assign jtag_tms_o      = tms_q;
    assign jtag_tdi_o      = tdi_q;
    assign jtag_trst_no    = trst_q;
endmodule

// File: doc/jtag_shift_ctrl.md
Name: jtag_shift_ctrl

Overview:
Standalone JTAG master that sequences the SoC debug TAP (jtag_tck/tms/tdi/tdo/trst_n) from a command/response interface. It replaces the simulation jtagdpi driver on FPGA/self-test builds, and lets an on-chip or board-level agent issue IR/DR scans to the debug module. It generates TCK by dividing `clock`, walks the TAP state machine, and returns captured TDO data.

Parameters:
CLK_DIV, 2, system clocks per TCK half-period (>=1); one TCK period = 2*CLK_DIV clocks
MAX_LEN, 32, maximum scan length in bits; data bus width

Ports:
clock  input  1  system clock
reset_ni  input  1  asynchronous active-low reset
cmd_valid_i  input  1  scan command valid
cmd_ready_o  output  1  command accepted when valid&ready
cmd_ir_i  input  1  1 = IR scan, 0 = DR scan
cmd_len_i  input  6  scan length in bits, legal 1..MAX_LEN
cmd_data_i  input  MAX_LEN  TDI data, LSB shifted first
reset_req_i  input  1  request TAP reset sequence (Test-Logic-Reset then Run-Test/Idle)
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready
rsp_data_o  output  MAX_LEN  captured TDO, bit i = i-th shifted bit, bits >= len zero
rsp_err_o  output  1  illegal length; no scan performed
busy_o  output  1  TCK sequence in progress
jtag_tck_o  output  1  TCK
jtag_tms_o  output  1  TMS
jtag_tdi_o  output  1  TDI
jtag_tdo_i  input  1  TDO from TAP
jtag_trst_no  output  1  TAP reset, active low

Behaviour:
- Only `clock`; reset is asynchronous active-low on reset_ni. All outputs registered.
- Reset values: tck 0, tms 1, tdi 0, trst_no 0, cmd_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0; state = TLR.
- trst_no rises on first clock edge after reset release; TLR sequence begins the following cycle.
- TCK period: phase counter 0..2*CLK_DIV-1; tck_o=1 when phase>=CLK_DIV. TMS/TDI updated when phase=0 (tck low), held whole period. TDO sampled on the clock edge where tck_o goes 0->1. tck_o held 0 when idle.
- States: TLR, IDLE, PRE, SHIFT, POST, RSP.
- TLR: 5 periods TMS=1, 1 period TMS=0 -> TAP in Run-Test/Idle; then IDLE. Entered from reset or reset_req_i in IDLE. No response generated.
- IDLE: cmd_ready_o = 1 iff not rsp_valid and not reset_req_i. reset_req_i wins over simultaneous cmd_valid_i.
- Accept: latch ir/len/data; first TCK period starts next cycle; busy_o=1 until back in IDLE/RSP.
- Illegal len (0 or >MAX_LEN): no TCK activity; go to RSP with rsp_err_o=1, rsp_data_o=0.
- PRE TMS sequence: DR 1,0,0 (Select-DR, Capture-DR, Shift-DR); IR 1,1,0,0.
- SHIFT: len periods; TDI=data[i]; TMS=0 except last bit TMS=1 (Exit1); TDO sampled each rising edge into bit i.
- POST: TMS 1 (Update), 0 (Run-Test/Idle).
- Total periods: DR len+5, IR len+6.
- RSP: rsp_valid_o held with stable data/err until rsp_ready_i; return to IDLE next cycle. No new command accepted while rsp_valid_o=1.
- reset_req_i ignored outside IDLE. Async reset mid-scan: immediate return to reset values; TLR re-run after release.

Test Plan:
- Reset release, CLK_DIV=2 -> trst_no 1 after 1 cycle; 6 TCK rising edges with TMS 1,1,1,1,1,0; cmd_ready_o=1 afterwards; TAP model in Run-Test/Idle.
- DR scan len=8 data=0xA5, TAP model bypass-loop (TDO = previous TDI, capture 0) -> 13 TCK periods (52 clocks); TDI bits 1,0,1,0,0,1,0,1; rsp_data=0x4A, rsp_err=0.
- IR scan len=5 data=0x01 to TAP model -> 11 periods; TMS 1,1,0,0,0,0,0,0,1,1,0; TAP IR=0x01; rsp_data = IR capture value 0x01 (bits 4:2 = 0).
- cmd_len=0 and cmd_len=33 -> no TCK toggles; rsp_valid with rsp_err=1, rsp_data=0.
- rsp_ready_i held 0 for 20 cycles after scan -> rsp_valid/data stable, cmd_ready_o=0, second cmd_valid not accepted; accepted the cycle after the response is consumed and the block is back in IDLE.
- reset_req_i and cmd_valid_i together in IDLE -> TLR sequence, command not accepted until done; async reset asserted mid-SHIFT -> tck=0, tms=1, trst_no=0 immediately, TLR repeats after release.
